// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I instruction decode, sitting directly in front of register_file.
// One pipeline register holds the decoded bundle. The register-file read
// addresses are driven combinationally from the incoming instruction when it
// is accepted, and from the held bundle's fields otherwise. This means the
// register file's registered read data always lines up with the bundle that
// is currently presented, including while the bundle is stalled.
//
// Parameters
//   XLEN          datapath width for PC and immediate (>= 32)
//   FENCE_AS_NOP  1: FENCE decodes as a NOP; 0: FENCE is flagged illegal
//
// Ports
//   clk_i, reset_i          clock; synchronous active-high reset
//   flush_i                 drop the held bundle and any incoming instruction
//   instr_valid_i/_ready_o  fetch handshake (instr_i, pc_i)
//   rs1_addr_o, rs2_addr_o  register-file read addresses
//   out_valid_o/out_ready_i execute handshake for the decoded bundle
//   pc_o, rd_addr_o, imm_o, funct3_o, alu_op_o, alu_src_imm_o, alu_src_pc_o,
//   reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o
//                           registered decoded bundle
//
// Jumps: alu_src_pc_o=1 with alu_src_imm_o=0 selects the link calculation
// (pc + 4); execute supplies the constant 4 whenever jump_o is set.
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int unsigned XLEN         = 32,
  parameter bit          FENCE_AS_NOP = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      funct3_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_src_imm_o,
  output logic            alu_src_pc_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o
);

  // Major opcodes
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation encoding seen by execute
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef enum logic [2:0] {
    IMM_ZERO,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic valid_reg;
  logic accept;

  assign instr_ready_o = !flush_i && (!valid_reg || out_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  // -------------------------------------------------------------------------
  // Field extraction
  // -------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign rd_field = instr_i[11:7];

  // Base (funct7 == 0) mapping of funct3 for OP / OP-IMM.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  imm_sel_e   imm_sel;
  logic [3:0] dec_alu_op;
  logic       dec_src_imm;
  logic       dec_src_pc;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_legal;

  always_comb begin
    imm_sel       = IMM_ZERO;
    dec_alu_op    = ALU_ADD;
    dec_src_imm   = 1'b0;
    dec_src_pc    = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_legal     = 1'b1;

    case (opcode)
      OPC_OP: begin
        dec_reg_write = 1'b1;
        dec_alu_op    = f3_to_alu(funct3);
        // funct7[5] only has meaning for ADD/SUB and SRL/SRA.
        if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_alu_op = ALU_SRA;
        end else if (funct7 != F7_BASE) begin
          dec_legal = 1'b0;
        end
      end

      OPC_OP_IMM: begin
        imm_sel       = IMM_I;
        dec_src_imm   = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = f3_to_alu(funct3);
        // Only the shift forms constrain the upper immediate bits.
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          dec_legal = 1'b0;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            dec_alu_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            dec_legal = 1'b0;
          end
        end
      end

      OPC_LOAD: begin
        imm_sel       = IMM_I;
        dec_src_imm   = 1'b1;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        // LB, LH, LW, LBU, LHU
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_legal = 1'b1;
          default:                                dec_legal = 1'b0;
        endcase
      end

      OPC_STORE: begin
        imm_sel       = IMM_S;
        dec_src_imm   = 1'b1;
        dec_mem_write = 1'b1;
        // SB, SH, SW
        dec_legal     = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end

      OPC_BRANCH: begin
        imm_sel    = IMM_B;
        dec_alu_op = ALU_SUB;
        dec_branch = 1'b1;
        // funct3 010/011 are unassigned branch encodings
        dec_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
      end

      OPC_LUI: begin
        imm_sel       = IMM_U;
        dec_alu_op    = ALU_PASS_B;
        dec_src_imm   = 1'b1;
        dec_reg_write = 1'b1;
      end

      OPC_AUIPC: begin
        imm_sel       = IMM_U;
        dec_alu_op    = ALU_ADD;
        dec_src_imm   = 1'b1;
        dec_src_pc    = 1'b1;
        dec_reg_write = 1'b1;
      end

      OPC_JAL: begin
        imm_sel       = IMM_J;
        dec_src_pc    = 1'b1;
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
      end

      OPC_JALR: begin
        imm_sel       = IMM_I;
        dec_src_pc    = 1'b1;
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
        dec_legal     = (funct3 == 3'b000);
      end

      OPC_MISC_MEM: begin
        // Single-hart in-order core: FENCE has nothing to order.
        dec_legal = FENCE_AS_NOP && (funct3 == 3'b000);
      end

      default: begin
        // Unknown opcodes and SYSTEM (ECALL/EBREAK/CSR) are not supported.
        dec_legal = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Immediate generation (sign bit is always instr[31])
  // -------------------------------------------------------------------------
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;

  always_comb begin
    imm32 = 32'd0;
    case (imm_sel)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'd0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  // -------------------------------------------------------------------------
  // Illegal / x0 gating of side effects
  // -------------------------------------------------------------------------
  logic [3:0] alu_op_next;
  logic       src_imm_next;
  logic       src_pc_next;
  logic       reg_write_next;
  logic       mem_read_next;
  logic       mem_write_next;
  logic       branch_next;
  logic       jump_next;
  logic       illegal_next;

  always_comb begin
    illegal_next   = !dec_legal;
    alu_op_next    = dec_legal ? dec_alu_op : ALU_ADD;
    src_imm_next   = dec_legal && dec_src_imm;
    src_pc_next    = dec_legal && dec_src_pc;
    // Writes to x0 are suppressed here so later stages never see them.
    reg_write_next = dec_legal && dec_reg_write && (rd_field != 5'd0);
    mem_read_next  = dec_legal && dec_mem_read;
    mem_write_next = dec_legal && dec_mem_write;
    branch_next    = dec_legal && dec_branch;
    jump_next      = dec_legal && dec_jump;
  end

  // -------------------------------------------------------------------------
  // Pipeline register
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] pc_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] imm_reg;
  logic [2:0]      funct3_reg;
  logic [3:0]      alu_op_reg;
  logic            src_imm_reg;
  logic            src_pc_reg;
  logic            reg_write_reg;
  logic            mem_read_reg;
  logic            mem_write_reg;
  logic            branch_reg;
  logic            jump_reg;
  logic            illegal_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      rd_reg        <= '0;
      imm_reg       <= '0;
      funct3_reg    <= '0;
      alu_op_reg    <= '0;
      src_imm_reg   <= 1'b0;
      src_pc_reg    <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      branch_reg    <= 1'b0;
      jump_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
    end else if (flush_i) begin
      // Bundle contents are left as-is; only the valid bit matters downstream.
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg     <= 1'b1;
      pc_reg        <= pc_i;
      rd_reg        <= rd_field;
      imm_reg       <= imm_ext;
      funct3_reg    <= funct3;
      alu_op_reg    <= alu_op_next;
      src_imm_reg   <= src_imm_next;
      src_pc_reg    <= src_pc_next;
      reg_write_reg <= reg_write_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      branch_reg    <= branch_next;
      jump_reg      <= jump_next;
      illegal_reg   <= illegal_next;
      rs1_reg       <= instr_i[19:15];
      rs2_reg       <= instr_i[24:20];
    end else if (out_ready_i) begin
      valid_reg <= 1'b0;
    end
  end

  // Read addresses: new fields on accept so data arrives with the bundle,
  // otherwise the held fields keep the register-file outputs stable.
  assign rs1_addr_o = accept ? instr_i[19:15] : rs1_reg;
  assign rs2_addr_o = accept ? instr_i[24:20] : rs2_reg;

  assign out_valid_o   = valid_reg;
  assign pc_o          = pc_reg;
  assign rd_addr_o     = rd_reg;
  assign imm_o         = imm_reg;
  assign funct3_o      = funct3_reg;
  assign alu_op_o      = alu_op_reg;
  assign alu_src_imm_o = src_imm_reg;
  assign alu_src_pc_o  = src_pc_reg;
  assign reg_write_o   = reg_write_reg;
  assign mem_read_o    = mem_read_reg;
  assign mem_write_o   = mem_write_reg;
  assign branch_o      = branch_reg;
  assign jump_o        = jump_reg;
  assign illegal_o     = illegal_reg;

endmodule
